// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares a single next-level cache port between NREQ lower-level requesters
// (for example I-cache and D-cache miss/writeback paths in front of a unified
// L2). Round-robin arbitration, one outstanding transaction at a time. The
// winner's command is latched, the next-level request/valid handshake is
// sequenced, and the response is returned only to the owner.
//
// Optional build macro:
//   CACHE_ARB_WB_PRIORITY_EN - when defined, pending writes (writebacks) are
//   arbitrated ahead of reads; round-robin order is kept among the writers.
//   When undefined, req_write has no effect on arbitration.
//
// Ports:
//   clock       in   1              system clock, rising edge
//   reset       in   1              asynchronous, active-low reset
//   req         in   NREQ           per-requester request
//   req_write   in   NREQ           per-requester 1=write, 0=read
//   req_addr    in   NREQ*ADDRBITS  per-requester address (slice i)
//   req_wdata   in   NREQ*WORDBITS  per-requester write data (slice i)
//   req_valid   out  NREQ           one-cycle completion pulse to owner
//   req_rdata   out  WORDBITS       read data, meaningful with req_valid
//   grant_id    out  IDBITS         index of current owner
//   busy        out  1              transaction in progress
//   nl_request  out  1              request to next level
//   nl_write    out  1              latched write flag
//   nl_addr     out  ADDRBITS       latched address
//   nl_wdata    out  WORDBITS       latched write data
//   nl_valid    in   1              next-level completion
//   nl_rdata    in   WORDBITS       next-level read data
//
// States:
//   state  | meaning
//   S_IDLE | no transaction; arbitrate among pending requests each edge
//   S_BUSY | command latched, nl_request high, waiting for nl_valid
//   S_DONE | req_valid pulse to owner, pointer advances, back to S_IDLE
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDRBITS = 32,
  parameter int WORDBITS = 32,
  localparam int IDBITS  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDRBITS-1:0] req_addr,
  input  logic [NREQ*WORDBITS-1:0] req_wdata,
  output logic [NREQ-1:0]          req_valid,
  output logic [WORDBITS-1:0]      req_rdata,
  output logic [IDBITS-1:0]        grant_id,
  output logic                     busy,
  output logic                     nl_request,
  output logic                     nl_write,
  output logic [ADDRBITS-1:0]      nl_addr,
  output logic [WORDBITS-1:0]      nl_wdata,
  input  logic                     nl_valid,
  input  logic [WORDBITS-1:0]      nl_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [IDBITS-1:0]    last_grant;
  logic                 lat_write;
  logic [ADDRBITS-1:0]  lat_addr;
  logic [WORDBITS-1:0]  lat_wdata;
  logic [WORDBITS-1:0]  rdata_q;
  logic [NREQ-1:0]      valid_q;

  logic [NREQ-1:0]      cand;
  logic                 win_found;
  logic [IDBITS-1:0]    win_id;
  logic                 sel_write;
  logic [ADDRBITS-1:0]  sel_addr;
  logic [WORDBITS-1:0]  sel_wdata;
  logic [NREQ-1:0]      owner_onehot;
  logic                 load;
  logic                 capture;

  // ---------------------------------------------------------------------------
  // Candidate set. With writeback priority, any pending write narrows the
  // field to writers only so dirty evictions drain before refills.
  // ---------------------------------------------------------------------------
`ifdef CACHE_ARB_WB_PRIORITY_EN
  logic [NREQ-1:0] writers;
  always_comb begin
    writers = req & req_write;
    cand    = (|writers) ? writers : req;
  end
`else
  always_comb begin
    cand = req;
  end
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: first candidate searching upward from last_grant+1,
  // wrapping modulo NREQ. k runs 1..NREQ so last_grant itself is tried last.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_id    = IDBITS'(idx);
      end
    end
  end

  // Command mux for the winner.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDBITS'(i) == win_id) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDRBITS +: ADDRBITS];
        sel_wdata = req_wdata[i*WORDBITS +: WORDBITS];
      end
    end
  end

  // Completion pulse target, decoded from the registered owner.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDBITS'(i) == grant_id) begin
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and strobes. nl_valid is only looked at in S_BUSY, so a
  // stray completion in S_IDLE or S_DONE has no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          load       = 1'b1;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (nl_valid) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. The pointer only advances in S_DONE, so a reset in the
  // middle of a transaction leaves requester 0 first in line again.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= IDBITS'(NREQ - 1);
      grant_id   <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      valid_q    <= '0;
    end else begin
      valid_q <= '0;
      if (load) begin
        grant_id  <= win_id;
        lat_write <= sel_write;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
      if (capture) begin
        // Captured for writes too; the owner simply ignores it.
        rdata_q <= nl_rdata;
        valid_q <= owner_onehot;
      end
      if (state == S_DONE) begin
        last_grant <= grant_id;
      end
    end
  end

  // nl_* depend only on state and latched registers, never on req directly.
  assign nl_request = (state == S_BUSY);
  assign nl_write   = lat_write;
  assign nl_addr    = lat_addr;
  assign nl_wdata   = lat_wdata;
  assign busy       = (state != S_IDLE);
  assign req_valid  = valid_q;
  assign req_rdata  = rdata_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
module tb_cache_port_arbiter;

  localparam int NREQ     = 2;
  localparam int ADDRBITS = 32;
  localparam int WORDBITS = 32;

`ifdef CACHE_ARB_WB_PRIORITY_EN
  localparam bit WB_PRI = 1'b1;
`else
  localparam bit WB_PRI = 1'b0;
`endif

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          req_write;
  logic [NREQ*ADDRBITS-1:0] req_addr;
  logic [NREQ*WORDBITS-1:0] req_wdata;
  logic [NREQ-1:0]          req_valid;
  logic [WORDBITS-1:0]      req_rdata;
  logic [0:0]               grant_id;
  logic                     busy;
  logic                     nl_request;
  logic                     nl_write;
  logic [ADDRBITS-1:0]      nl_addr;
  logic [WORDBITS-1:0]      nl_wdata;
  logic                     nl_valid;
  logic [WORDBITS-1:0]      nl_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  cache_port_arbiter #(
    .NREQ(NREQ), .ADDRBITS(ADDRBITS), .WORDBITS(WORDBITS)
  ) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_valid(req_valid), .req_rdata(req_rdata), .grant_id(grant_id), .busy(busy),
    .nl_request(nl_request), .nl_write(nl_write), .nl_addr(nl_addr), .nl_wdata(nl_wdata),
    .nl_valid(nl_valid), .nl_rdata(nl_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int nreq_cycles;
    logic [0:0] exp_g;

    reset     = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = {32'h0000_2000, 32'h0000_1000};
    req_wdata = {32'h2222_2222, 32'h1111_1111};
    nl_valid  = 1'b0;
    nl_rdata  = '0;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_nl_request", nl_request, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_nl_addr", nl_addr, 0);
    check("rst_req_rdata", req_rdata, 0);
    reset = 1'b1;
    step();

    // Single read from requester 0, two wait cycles at the next level
    req = 2'b01;
    step();
    nreq_cycles = 0;
    check("rd_grant_id", grant_id, 0);
    check("rd_nl_addr", nl_addr, 32'h0000_1000);
    check("rd_nl_write", nl_write, 0);
    for (int c = 0; c < 3; c++) begin
      if (nl_request) nreq_cycles++;
      if (c == 2) begin
        nl_valid = 1'b1;
        nl_rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    nl_valid = 1'b0;
    check("rd_nl_request_cycles", nreq_cycles, 3);
    check("rd_nl_request_done", nl_request, 0);
    check("rd_req_valid", req_valid, 2'b01);
    check("rd_req_rdata", req_rdata, 32'hDEAD_BEEF);
    check("rd_busy_done", busy, 1);
    step();
    req = 2'b00;
    check("rd_req_valid_once", req_valid, 2'b00);
    check("rd_busy_idle", busy, 0);

    // Stray nl_valid in IDLE
    nl_valid = 1'b1;
    step();
    nl_valid = 1'b0;
    check("stray_idle_busy", busy, 0);
    check("stray_idle_valid", req_valid, 0);

    // Priority test, last_grant is 0: reader 1 vs writer 0
    req       = 2'b11;
    req_write = 2'b01;
    req_addr  = {32'h0000_4000, 32'h0000_3000};
    step();
    exp_g = WB_PRI ? 1'b0 : 1'b1;
    check("pri_grant_id", grant_id, exp_g);
    check("pri_nl_write", nl_write, WB_PRI ? 1 : 0);
    check("pri_nl_addr", nl_addr, WB_PRI ? 32'h0000_3000 : 32'h0000_4000);
    check("pri_nl_wdata", nl_wdata, WB_PRI ? 32'h1111_1111 : 32'h2222_2222);
    nl_valid = 1'b1;
    nl_rdata = 32'h0BAD_F00D;
    step();
    check("pri_req_valid", req_valid, WB_PRI ? 2'b01 : 2'b10);
    // nl_valid left high through DONE: must be ignored there
    step();
    nl_valid  = 1'b0;
    req       = 2'b00;
    req_write = 2'b00;
    check("stray_done_valid", req_valid, 0);
    check("stray_done_busy", busy, 0);
    check("stray_done_rdata", req_rdata, 32'h0BAD_F00D);
    step();
    check("stray_done_stay_idle", busy, 0);

    // Reset in the middle of a write from requester 1
    req       = 2'b10;
    req_write = 2'b10;
    req_addr  = {32'h0000_5000, 32'h0000_3000};
    step();
    check("mid_grant_id", grant_id, 1);
    check("mid_nl_write", nl_write, 1);
    check("mid_nl_request", nl_request, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_async_nl_request", nl_request, 0);
    check("mid_async_busy", busy, 0);
    step();
    check("mid_no_valid", req_valid, 0);
    check("mid_nl_addr_cleared", nl_addr, 0);
    #3;
    reset     = 1'b1;
    req       = 2'b11;
    req_write = 2'b00;
    nl_valid  = 1'b1;
    step();

    // Continuous requests, zero-wait next level: 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      exp_g = t[0];
      check($sformatf("rr%0d_grant", t), grant_id, exp_g);
      check($sformatf("rr%0d_busy", t), busy, 1);
      check($sformatf("rr%0d_nl_request", t), nl_request, 1);
      nl_rdata = 32'hA5A5_0000 + t;
      step();
      check($sformatf("rr%0d_valid", t), req_valid, exp_g ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_rdata", t), req_rdata, 32'hA5A5_0000 + t);
      step();
      check($sformatf("rr%0d_idle_gap", t), busy, 0);
      check($sformatf("rr%0d_valid_off", t), req_valid, 0);
      step();
    end
    nl_valid = 1'b0;
    req      = 2'b00;
    // The loop leaves the FSM in BUSY for a fifth grant (requester 0); finish it.
    check("rr_tail_grant", grant_id, 0);
    nl_valid = 1'b1;
    step();
    nl_valid = 1'b0;
    step();
    step();
    check("rr_tail_idle", busy, 0);

    // Abort attempt: requester 0 drops req during BUSY (last_grant is 0, only 0 requests)
    req      = 2'b01;
    req_addr = {32'h0000_2000, 32'h0000_6000};
    step();
    req = 2'b00;
    check("abort_grant", grant_id, 0);
    check("abort_addr", nl_addr, 32'h0000_6000);
    step();
    check("abort_still_busy", busy, 1);
    check("abort_still_request", nl_request, 1);
    nl_valid = 1'b1;
    nl_rdata = 32'hCAFE_F00D;
    step();
    nl_valid = 1'b0;
    check("abort_valid", req_valid, 2'b01);
    check("abort_rdata", req_rdata, 32'hCAFE_F00D);
    step();
    check("abort_valid_once", req_valid, 0);
    check("abort_idle", busy, 0);
    step();
    check("abort_stay_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
